spi_reg_bank: RTL and testbench

Consumes decoded SPI transactions (read_write, addr, data, valid) from the SPI deserializer and commits writes into the peripheral control register bank. Outputs drive the output-enable, PWM-enable and PWM-duty logic downstream. valid is a level that can stay high for many clk cycles, so the block edge-detects it and commits each transaction exactly once. Read transactions and out-of-range addresses are dropped and counted.

---
 rtl/spi_reg_bank_pkg.sv | 27 ++
 rtl/spi_reg_bank_rise_detect.sv | 24 ++
 rtl/spi_reg_bank.sv | 103 ++++++++++
 tb/tb_spi_reg_bank.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the peripheral control register bank: widths, fixed
// register address map and the captured SPI transaction payload.
package spi_reg_bank_pkg;

  localparam int unsigned REG_W    = 8;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned MAX_REGS = 5;

  localparam int unsigned ADDR_EN_OUT_LO = 0;
  localparam int unsigned ADDR_EN_OUT_HI = 1;
  localparam int unsigned ADDR_EN_PWM_LO = 2;
  localparam int unsigned ADDR_EN_PWM_HI = 3;
  localparam int unsigned ADDR_PWM_DUTY  = 4;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } spi_txn_t;

  // True when addr selects one of the first num_regs implemented registers.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       num_regs);
    return (addr < ADDR_W'(num_regs));
  endfunction

endpackage

// File: rtl/spi_reg_bank_rise_detect.sv
// Single-bit registered rising-edge detector; the history flop's reset value
// is a parameter so a level already high at reset release is not an edge.
module spi_reg_bank_rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Commits decoded SPI write transactions into the peripheral control register
// bank; reads and out-of-range addresses are dropped and counted.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 5,
  parameter int unsigned ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read_write,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [REG_W-1:0]     data,
  input  logic                 valid,
  output logic [REG_W-1:0]     en_reg_out_7_0,
  output logic [REG_W-1:0]     en_reg_out_15_8,
  output logic [REG_W-1:0]     en_reg_pwm_7_0,
  output logic [REG_W-1:0]     en_reg_pwm_15_8,
  output logic [REG_W-1:0]     pwm_duty_cycle,
  output logic                 wr_strobe,
  output logic [ERR_CNT_W-1:0] drop_cnt
);

  logic                 start_c;
  spi_txn_t             cap_q;
  logic                 cap_vld_q;
  logic                 commit_c;
  logic                 drop_c;
  logic [REG_W-1:0]     regs_q [MAX_REGS];
  logic                 wr_strobe_q;
  logic [ERR_CNT_W-1:0] drop_cnt_q;

  // valid is a level; only its rising edge starts a transaction.
  spi_reg_bank_rise_detect #(
    .RST_VAL (1'b1)
  ) u_valid_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (valid),
    .rise_c (start_c)
  );

  // Stage 1: capture the transaction on the valid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= start_c;
      if (start_c) begin
        cap_q.rw   <= read_write;
        cap_q.addr <= addr;
        cap_q.data <= data;
      end
    end
  end

  // Stage 2 decision: accept in-range writes, drop everything else.
  always_comb begin
    commit_c = 1'b0;
    drop_c   = 1'b0;
    if (cap_vld_q) begin
      commit_c = cap_q.rw & addr_in_range(cap_q.addr, NUM_REGS);
      drop_c   = ~commit_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_REGS; i++) begin
        if (commit_c && (cap_q.addr == ADDR_W'(i))) begin
          regs_q[i] <= cap_q.data;
        end
      end
    end
  end

  // Strobe and saturating drop counter; the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_strobe_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_strobe_q <= commit_c;
      if (drop_c && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
  assign wr_strobe       = wr_strobe_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: full map instance plus a NUM_REGS=3 instance.
module tb_spi_reg_bank;

  logic       clk;
  logic       rst_n;
  logic       read_write;
  logic [6:0] addr;
  logic [7:0] data;
  logic       valid;
  logic       valid3;

  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic       wr_strobe;
  logic [3:0] drop_cnt;

  logic [7:0] out_lo3, out_hi3, pwm_lo3, pwm_hi3, duty3;
  logic       wr_strobe3;
  logic [3:0] drop_cnt3;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int s0;

  spi_reg_bank #(.NUM_REGS(5), .ERR_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .read_write(read_write), .addr(addr), .data(data),
    .valid(valid), .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi), .pwm_duty_cycle(duty),
    .wr_strobe(wr_strobe), .drop_cnt(drop_cnt)
  );

  spi_reg_bank #(.NUM_REGS(3), .ERR_CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .read_write(read_write), .addr(addr), .data(data),
    .valid(valid3), .en_reg_out_7_0(out_lo3), .en_reg_out_15_8(out_hi3),
    .en_reg_pwm_7_0(pwm_lo3), .en_reg_pwm_15_8(pwm_hi3), .pwm_duty_cycle(duty3),
    .wr_strobe(wr_strobe3), .drop_cnt(drop_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input logic to3);
    @(negedge clk);
    read_write = rw;
    addr       = a;
    data       = d;
    if (to3) valid3 = 1'b1;
    else     valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    valid3 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; read_write = 1'b0; addr = '0; data = '0; valid = 1'b0; valid3 = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("rst_out_lo", 32'(out_lo), 32'h0);
    check("rst_duty", 32'(duty), 32'h0);
    check("rst_strobe", 32'(wr_strobe), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);

    // Long valid level: one commit, 2 clk latency, one strobe.
    s0 = strobe_cnt;
    @(negedge clk);
    read_write = 1'b1; addr = 7'h04; data = 8'hA5; valid = 1'b1;
    @(negedge clk);
    check("lat1_duty", 32'(duty), 32'h0);
    check("lat1_strobe", 32'(wr_strobe), 32'h0);
    @(negedge clk);
    check("lat2_duty", 32'(duty), 32'hA5);
    check("lat2_strobe", 32'(wr_strobe), 32'h1);
    @(negedge clk);
    check("lat3_strobe", 32'(wr_strobe), 32'h0);
    idle(3);
    valid = 1'b0;
    idle(3);
    check("long_strobe_cnt", 32'(strobe_cnt - s0), 32'd1);
    check("long_drop", 32'(drop_cnt), 32'h0);

    // Read is dropped.
    s0 = strobe_cnt;
    pulse(1'b0, 7'h02, 8'hFF, 1'b0);
    idle(3);
    check("rd_pwm_lo", 32'(pwm_lo), 32'h0);
    check("rd_drop", 32'(drop_cnt), 32'd1);
    check("rd_strobe_cnt", 32'(strobe_cnt - s0), 32'd0);

    // Out-of-range writes are dropped.
    pulse(1'b1, 7'h05, 8'h33, 1'b0);
    pulse(1'b1, 7'h7F, 8'h33, 1'b0);
    idle(3);
    check("oor_drop", 32'(drop_cnt), 32'd3);
    check("oor_out_lo", 32'(out_lo), 32'h0);
    check("oor_out_hi", 32'(out_hi), 32'h0);
    check("oor_pwm_hi", 32'(pwm_hi), 32'h0);
    check("oor_duty", 32'(duty), 32'hA5);

    // NUM_REGS=3: address 3 drops, address 2 commits.
    pulse(1'b1, 7'h03, 8'h33, 1'b1);
    pulse(1'b1, 7'h02, 8'h44, 1'b1);
    idle(3);
    check("n3_drop", 32'(drop_cnt3), 32'd1);
    check("n3_pwm_hi", 32'(pwm_hi3), 32'h0);
    check("n3_pwm_lo", 32'(pwm_lo3), 32'h44);
    check("n3_main_drop", 32'(drop_cnt), 32'd3);

    // Back-to-back single-cycle writes to every register.
    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) pulse(1'b1, 7'(i), 8'(i + 1), 1'b0);
    idle(3);
    check("b2b_out_lo", 32'(out_lo), 32'h01);
    check("b2b_out_hi", 32'(out_hi), 32'h02);
    check("b2b_pwm_lo", 32'(pwm_lo), 32'h03);
    check("b2b_pwm_hi", 32'(pwm_hi), 32'h04);
    check("b2b_duty", 32'(duty), 32'h05);
    check("b2b_strobe_cnt", 32'(strobe_cnt - s0), 32'd5);
    check("b2b_drop", 32'(drop_cnt), 32'd3);

    // Saturation of the drop counter.
    for (int i = 0; i < 11; i++) pulse(1'b0, 7'h00, 8'h00, 1'b0);
    idle(3);
    check("sat_14", 32'(drop_cnt), 32'd14);
    for (int i = 0; i < 9; i++) pulse(1'b0, 7'h00, 8'h00, 1'b0);
    idle(3);
    check("sat_15", 32'(drop_cnt), 32'd15);
    check("sat_out_lo", 32'(out_lo), 32'h01);

    // Reset with a capture pending, released while valid is still high.
    s0 = strobe_cnt;
    @(negedge clk);
    read_write = 1'b1; addr = 7'h00; data = 8'h77; valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(4);
    check("rstmid_out_lo", 32'(out_lo), 32'h0);
    check("rstmid_duty", 32'(duty), 32'h0);
    check("rstmid_drop", 32'(drop_cnt), 32'h0);
    check("rstmid_strobe_cnt", 32'(strobe_cnt - s0), 32'd0);
    valid = 1'b0;
    pulse(1'b1, 7'h00, 8'h77, 1'b0);
    idle(3);
    check("rstmid_new_edge", 32'(out_lo), 32'h77);
    check("rstmid_new_strobe", 32'(strobe_cnt - s0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
